// File: rtl/uart_fifo.sv
// UART with TX/RX FIFOs, ready/valid flow control, overflow and frame-error pulses.
// Define UART_PARITY_EN to add one even-parity bit after D7 in both directions.
module uart_fifo #(
  parameter int CLK_PER_BIT = 868,
  parameter int FIFO_DEPTH  = 16,
  parameter int CW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          UART_RX,
  output logic          UART_TX,
  input  logic          tx_valid,
  input  logic [7:0]    tx_data,
  output logic          tx_ready,
  output logic [CW-1:0] tx_count,
  output logic          rx_valid,
  output logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic [CW-1:0] rx_count,
  output logic          rx_overflow,
  output logic          rx_frame_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_push, tx_pop, tx_empty;
  logic [7:0]    tx_head;

  assign tx_ready = (tx_cnt_q != CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = tx_valid && tx_ready;
  assign tx_head  = tx_mem[tx_rd_q];
  assign tx_count = tx_cnt_q;

  always_comb begin
    tx_wr_d  = tx_wr_q + AW'(tx_push);
    tx_rd_d  = tx_rd_q + AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
  end

  // NOTE: storage arrays carry no reset; only pointers and counts define validity.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_q] <= tx_data;
  end

  // ---------------- TX FSM ----------------
  state_e        tx_state_q, tx_state_d;
  logic [TW-1:0] tx_timer_q, tx_timer_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_tick;
`ifdef UART_PARITY_EN
  logic          tx_par_q, tx_par_d;
`endif

  assign tx_tick = (tx_timer_q == T_LAST);
  assign UART_TX = tx_line_q;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no latch can be inferred.
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    tx_line_d  = 1'b1;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    if (tx_state_q != S_IDLE) tx_timer_d = tx_tick ? '0 : tx_timer_q + TW'(1);
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
`ifdef UART_PARITY_EN
          tx_par_d   = ^tx_head;
`endif
          tx_timer_d = '0;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        tx_line_d = 1'b0;
        if (tx_tick) begin
          tx_idx_d   = '0;
          tx_state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_line_d = tx_shift_q[0];
        if (tx_tick) begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_idx_d   = tx_idx_q + 3'd1;
`ifdef UART_PARITY_EN
          if (tx_idx_q == 3'd7) tx_state_d = S_PARITY;
`else
          if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        tx_line_d = tx_par_q;
        if (tx_tick) tx_state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tx_tick) begin
          // Chain straight into the next start bit when more data is queued.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
`ifdef UART_PARITY_EN
            tx_par_d   = ^tx_head;
`endif
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  // ---------------- RX path ----------------
  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  state_e        rx_state_q, rx_state_d;
  logic [TW-1:0] rx_timer_q, rx_timer_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_armed_q, rx_armed_d;
  logic          rx_push_q, rx_push_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          rx_tick, rx_stop_ok;
`ifdef UART_PARITY_EN
  logic          rx_par_q, rx_par_d;
  assign rx_stop_ok = rx_sync_q && !rx_par_q;
`else
  assign rx_stop_ok = rx_sync_q;
`endif

  assign rx_tick = (rx_timer_q == T_LAST);

  always_comb begin
    rx_meta_d  = UART_RX;
    rx_sync_d  = rx_meta_q;
    rx_state_d = rx_state_q;
    rx_timer_d = rx_timer_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    // After a bad stop bit the receiver stays disarmed until the line is seen high.
    rx_armed_d = rx_armed_q | rx_sync_q;
    rx_push_d  = 1'b0;
    rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d   = rx_par_q;
`endif
    case (rx_state_q)
      S_IDLE: begin
        rx_timer_d = '0;
        if (rx_armed_q && !rx_sync_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_timer_q == T_HALF) begin
          rx_timer_d = '0;
          rx_idx_d   = '0;
`ifdef UART_PARITY_EN
          rx_par_d   = 1'b0;
`endif
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          rx_timer_d = rx_timer_q + TW'(1);
        end
      end
      S_DATA: begin
        rx_timer_d = rx_tick ? '0 : rx_timer_q + TW'(1);
        if (rx_tick) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
`ifdef UART_PARITY_EN
          rx_par_d   = rx_par_q ^ rx_sync_q;
          if (rx_idx_q == 3'd7) rx_state_d = S_PARITY;
`else
          if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        rx_timer_d = rx_tick ? '0 : rx_timer_q + TW'(1);
        if (rx_tick) begin
          rx_par_d   = rx_par_q ^ rx_sync_q;
          rx_state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        rx_timer_d = rx_tick ? '0 : rx_timer_q + TW'(1);
        if (rx_tick) begin
          rx_state_d = S_IDLE;
          if (rx_stop_ok) begin
            rx_push_d = 1'b1;
          end else begin
            rx_ferr_d  = 1'b1;
            rx_armed_d = 1'b0;
          end
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // ---------------- RX FIFO (first-word-fall-through) ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_pop, rx_accept;

  assign rx_valid  = (rx_cnt_q != '0);
  assign rx_pop    = rx_ready && rx_valid;
  assign rx_accept = rx_push_q && ((rx_cnt_q != CW'(FIFO_DEPTH)) || rx_pop);
  assign rx_data   = rx_valid ? rx_mem[rx_rd_q] : 8'h00;
  assign rx_count  = rx_cnt_q;
  assign rx_overflow    = rx_ovf_q;
  assign rx_frame_error = rx_ferr_q;

  always_comb begin
    rx_wr_d  = rx_wr_q + AW'(rx_accept);
    rx_rd_d  = rx_rd_q + AW'(rx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_accept) - CW'(rx_pop);
    rx_ovf_d = rx_push_q && !rx_accept;
  end

  always_ff @(posedge clock) begin
    if (rx_accept) rx_mem[rx_wr_q] <= rx_shift_q;
  end

  // ---------------- State registers ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      tx_state_q <= S_IDLE;
      tx_timer_q <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_timer_q <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_armed_q <= 1'b1;
      rx_push_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovf_q   <= 1'b0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
      rx_par_q   <= 1'b0;
`endif
    end else begin
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_timer_q <= rx_timer_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_armed_q <= rx_armed_d;
      rx_push_q  <= rx_push_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovf_q   <= rx_ovf_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
      rx_par_q   <= rx_par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo (CLK_PER_BIT=4, FIFO_DEPTH=4); frames are
// modelled from byte values and compared bit-by-bit at bit centres.
module tb_uart_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          UART_RX, UART_TX;
  logic          tx_valid = 1'b0;
  logic [7:0]    tx_data  = 8'h00;
  logic          tx_ready;
  logic [CW-1:0] tx_count;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready = 1'b0;
  logic [CW-1:0] rx_count;
  logic          rx_overflow, rx_frame_error;

  logic loop_en = 1'b0;
  logic rx_drv  = 1'b1;
  assign UART_RX = loop_en ? UART_TX : rx_drv;

  int checks = 0;
  int errors = 0;
  int fe_seen = 0;
  int ovf_seen = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];

  uart_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .UART_RX(UART_RX), .UART_TX(UART_TX),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_count(tx_count),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .rx_frame_error(rx_frame_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rx_frame_error) fe_seen <= fe_seen + 1;
    if (rx_overflow)    ovf_seen <= ovf_seen + 1;
  end

  // Line image of one frame, LSB first: start, D0..D7, [even parity], stop.
  function automatic logic [NB-1:0] make_frame(input logic [7:0] b, input logic stop);
    logic [NB-1:0] f;
    f = '0;
    f[8:1] = b;
`ifdef UART_PARITY_EN
    f[9] = ^b;
`endif
    f[NB-1] = stop;
    return f;
  endfunction

  task automatic push_byte(input logic [7:0] b, output int waits);
    @(negedge clock);
    tx_valid = 1'b1;
    tx_data  = b;
    waits = 0;
    while (!tx_ready && waits < 400) begin
      @(negedge clock);
      waits++;
    end
    if (!tx_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: tx_ready stayed %b, required 1", tx_ready);
    end
    @(posedge clock); #1;
    tx_valid = 1'b0;
  endtask

  // Waits for the start bit, then checks n consecutive frames from tx_exp_q.
  task automatic watch_tx_frames(input int n, output int lat);
    logic [NB-1:0] f;
    logic [7:0] b;
    lat = 0;
    while (UART_TX !== 1'b0 && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    if (UART_TX !== 1'b0) begin
      checks++; errors++;
      $display("FAIL tx_start_timeout: UART_TX=%b, required 0", UART_TX);
      return;
    end
    for (int fr = 0; fr < n; fr++) begin
      b = tx_exp_q.pop_front();
      f = make_frame(b, 1'b1);
      for (int k = 0; k < NB; k++) begin
        repeat ((fr == 0 && k == 0) ? 2 : CPB) @(posedge clock);
        #1;
        checks++;
        if (UART_TX !== f[k]) begin
          errors++;
          $display("FAIL tx_bit frame %0d byte %h bit %0d: got %b, required %b", fr, b, k, UART_TX, f[k]);
        end
      end
    end
  endtask

  task automatic send_frame(input logic [NB-1:0] f);
    @(negedge clock);
    for (int k = 0; k < NB; k++) begin
      rx_drv = f[k];
      repeat (CPB) @(negedge clock);
    end
    rx_drv = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic pop_one(input logic [7:0] exp, input string name);
    @(negedge clock);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp) begin
      errors++;
      $display("FAIL %s: rx_valid=%b rx_data=%h, required 1/%h", name, rx_valid, rx_data, exp);
    end
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({UART_TX, tx_ready, rx_valid, rx_overflow, rx_frame_error} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags: tx/ready/valid/ovf/ferr=%b, required 11000",
               {UART_TX, tx_ready, rx_valid, rx_overflow, rx_frame_error});
    end
    checks++;
    if (tx_count !== '0 || rx_count !== '0 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_counts: tx_count=%0d rx_count=%0d rx_data=%h, required 0/0/00", tx_count, rx_count, rx_data);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [3];
    int w, lat, fe0;
    bytes[0] = 8'hA5;
    bytes[1] = 8'($urandom_range(255));
    bytes[2] = 8'($urandom_range(255));
    loop_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fe0 = fe_seen;
      tx_exp_q.push_back(bytes[i]);
      push_byte(bytes[i], w);
      watch_tx_frames(1, lat);
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL tx_latency: start bit after %0d edges, required 2", lat);
      end
      repeat (10) @(posedge clock);
      #1;
      checks++;
      if (rx_valid !== 1'b1 || rx_data !== bytes[i] || rx_count !== CW'(1)) begin
        errors++;
        $display("FAIL loopback_rx: valid=%b data=%h count=%0d, required 1/%h/1", rx_valid, rx_data, rx_count, bytes[i]);
      end
      checks++;
      if (fe_seen != fe0) begin
        errors++;
        $display("FAIL loopback_ferr: %0d frame errors, required 0", fe_seen - fe0);
      end
      pop_one(bytes[i], "loopback_pop");
      checks++;
      if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
        errors++;
        $display("FAIL loopback_empty: valid=%b data=%h, required 0/00", rx_valid, rx_data);
      end
    end
    loop_en = 1'b0;
  endtask

  task automatic test_tx_full();
    int w, lat;
    for (int i = 1; i <= 6; i++) tx_exp_q.push_back(8'(i));
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          push_byte(8'(i + 1), w);
          if (i == 4) begin
            checks++;
            if (tx_ready !== 1'b0 || tx_count !== CW'(DEPTH)) begin
              errors++;
              $display("FAIL tx_full_flag: ready=%b count=%0d, required 0/%0d", tx_ready, tx_count, DEPTH);
            end
          end
          if (i == 5) begin
            checks++;
            if (w == 0) begin
              errors++;
              $display("FAIL tx_full_hold: sixth byte waited %0d cycles, required >0", w);
            end
          end
        end
      end
      watch_tx_frames(6, lat);
    join
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if (tx_count !== '0 || tx_ready !== 1'b1 || UART_TX !== 1'b1) begin
      errors++;
      $display("FAIL tx_drain: count=%0d ready=%b line=%b, required 0/1/1", tx_count, tx_ready, UART_TX);
    end
  endtask

  task automatic test_rx_overflow();
    logic [7:0] b;
    int ovf0;
    ovf0 = ovf_seen;
    rx_exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(255));
      if (i < DEPTH) rx_exp_q.push_back(b);
      send_frame(make_frame(b, 1'b1));
      if (i == DEPTH - 1) begin
        checks++;
        if (rx_count !== CW'(DEPTH) || ovf_seen != ovf0) begin
          errors++;
          $display("FAIL rx_fill: count=%0d ovf=%0d, required %0d/0", rx_count, ovf_seen - ovf0, DEPTH);
        end
      end
    end
    checks++;
    if (rx_count !== CW'(DEPTH) || ovf_seen != ovf0 + 1) begin
      errors++;
      $display("FAIL rx_overflow: count=%0d ovf=%0d, required %0d/1", rx_count, ovf_seen - ovf0, DEPTH);
    end
    while (rx_exp_q.size() > 0) pop_one(rx_exp_q.pop_front(), "rx_overflow_order");
    checks++;
    if (rx_valid !== 1'b0 || rx_count !== '0) begin
      errors++;
      $display("FAIL rx_overflow_empty: valid=%b count=%0d, required 0/0", rx_valid, rx_count);
    end
  endtask

  task automatic test_frame_error();
    logic [7:0] b;
    int fe0;
    fe0 = fe_seen;
    send_frame(make_frame(8'h3C, 1'b0));
    checks++;
    if (fe_seen != fe0 + 1 || rx_count !== '0) begin
      errors++;
      $display("FAIL frame_error: ferr=%0d count=%0d, required 1/0", fe_seen - fe0, rx_count);
    end
    b = 8'($urandom_range(255));
    send_frame(make_frame(b, 1'b1));
    checks++;
    if (fe_seen != fe0 + 1 || rx_count !== CW'(1)) begin
      errors++;
      $display("FAIL frame_recover: ferr=%0d count=%0d, required 1/1", fe_seen - fe0, rx_count);
    end
    pop_one(b, "frame_recover_data");
  endtask

  task automatic test_glitch_parity();
    int fe0;
    logic [NB-1:0] f;
    fe0 = fe_seen;
    @(negedge clock);
    rx_drv = 1'b0;
    @(negedge clock);
    rx_drv = 1'b1;
    repeat (16) @(negedge clock);
    checks++;
    if (rx_count !== '0 || rx_valid !== 1'b0 || fe_seen != fe0) begin
      errors++;
      $display("FAIL glitch: count=%0d valid=%b ferr=%0d, required 0/0/0", rx_count, rx_valid, fe_seen - fe0);
    end
`ifdef UART_PARITY_EN
    f = make_frame(8'h07, 1'b1);
    f[9] = ~f[9];
    send_frame(f);
    checks++;
    if (fe_seen != fe0 + 1 || rx_count !== '0) begin
      errors++;
      $display("FAIL parity_bad: ferr=%0d count=%0d, required 1/0", fe_seen - fe0, rx_count);
    end
    f = make_frame(8'h07, 1'b1);
    send_frame(f);
    pop_one(8'h07, "parity_good");
`else
    f = make_frame(8'h07, 1'b1);
    send_frame(f);
    pop_one(8'h07, "post_glitch_data");
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b [3];
    logic [7:0] nb;
    logic [NB-1:0] f;
    int w, lat;
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom_range(255));
      push_byte(b[i], w);
    end
    // First frame started after the third push; move to the middle of D3.
    repeat (18) @(posedge clock);
    #1;
    f = make_frame(b[0], 1'b1);
    checks++;
    if (tx_count !== CW'(2) || UART_TX !== f[4]) begin
      errors++;
      $display("FAIL pre_reset: count=%0d line=%b, required 2/%b", tx_count, UART_TX, f[4]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (UART_TX !== 1'b1 || tx_count !== '0 || tx_ready !== 1'b1 || rx_count !== '0) begin
      errors++;
      $display("FAIL mid_reset: line=%b tx_count=%0d ready=%b rx_count=%0d, required 1/0/1/0",
               UART_TX, tx_count, tx_ready, rx_count);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tx_exp_q.delete();
    nb = 8'($urandom_range(255));
    tx_exp_q.push_back(nb);
    push_byte(nb, w);
    watch_tx_frames(1, lat);
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL post_reset_latency: start bit after %0d edges, required 2", lat);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_tx_full();
    test_rx_overflow();
    test_frame_error();
    test_glitch_parity();
    test_reset_mid_frame();
    repeat (4) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
# uart_fifo

Parametrised UART with transmit and receive FIFOs. It is the next generation of the simple single-byte `uart` used both on the Falcon3 GPIO serial link and as the bench-side stimulus driver. It adds configurable bit timing and FIFO depth, first-word-fall-through receive, ready/valid flow control on both directions, and error reporting. It sits between the CPU peripheral bus (or a testbench byte source) and the `GPIO_0[1:0]` serial pins.

## Interface
- `CLK_PER_BIT`, 868 — clocks per serial bit (100 MHz / 115200); legal range ≥4.
- `FIFO_DEPTH`, 16 — entries in each of the TX and RX FIFOs; power of two, ≥2.
- `CW`, $clog2(FIFO_DEPTH)+1 — width of the count outputs (derived; do not override).

Ports:
- `clock` in 1 — single clock; all logic on its rising edge.
- `reset` in 1 — asynchronous, active-high.
- `UART_RX` in 1 — serial input, asynchronous to `clock`.
- `UART_TX` out 1 — serial output, registered, idles high.
- `tx_valid` in 1 — byte offered to the TX FIFO.
- `tx_data` in 8 — byte to transmit.
- `tx_ready` out 1 — TX FIFO not full.
- `tx_count` out CW — TX FIFO occupancy, excluding the byte currently being shifted.
- `rx_valid` out 1 — RX FIFO not empty.
- `rx_data` out 8 — head of the RX FIFO; 0 when empty.
- `rx_ready` in 1 — pop the head when `rx_valid`.
- `rx_count` out CW — RX FIFO occupancy.
- `rx_overflow` out 1 — one-cycle pulse: a received byte was dropped.
- `rx_frame_error` out 1 — one-cycle pulse: stop bit (or parity) bad; byte dropped.

## Operation
- **Reset values:** `UART_TX`=1, `tx_ready`=1, `tx_count`=0, `rx_valid`=0, `rx_data`=0, `rx_count`=0, both pulse outputs 0, FSMs in IDLE, FIFO pointers 0.
- **TX push:** occurs when `tx_valid && tx_ready`. When the FIFO is full, `tx_valid` is ignored and no byte is lost internally.
- **TX FSM states:** IDLE → START → DATA (8 bits, LSB first) → [PARITY] → STOP → IDLE.
  - In IDLE, if the FIFO is non-empty, pop the head into the shift register.
  - Each state holds for exactly CLK_PER_BIT clocks, counted by a bit-timer.
  - At the end of STOP, if the FIFO is non-empty, go directly to START (no idle gap). Otherwise go to IDLE.
- **RX synchroniser:** 2-flop synchroniser on `UART_RX`, reset to 1.
- **RX FSM states:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: a synchronised low level moves the FSM to START.
  - START: wait CLK_PER_BIT/2 (integer floor), then resample. If high, treat it as a glitch and return to IDLE. If low, go to DATA.
  - DATA, PARITY, STOP: sample every CLK_PER_BIT clocks thereafter (bit centres).
  - STOP sample high and parity OK: push the byte into the RX FIFO.
  - STOP sample low or parity bad: pulse `rx_frame_error` and discard the byte. The FSM returns to IDLE and only re-arms after seeing line high (break holds off).
- **RX push on full:** the push succeeds if the FIFO is not full, or if `rx_ready && rx_valid` in the same cycle. Otherwise the byte is dropped and `rx_overflow` pulses.
- **RX pop:** `rx_ready && rx_valid`. `rx_ready` while empty is ignored.
- **Simultaneous push and pop:** on either FIFO, the count is unchanged and pointers wrap modulo FIFO_DEPTH.

## Timing
- **TX latency:** for a push at rising edge N with the FSM idle, `UART_TX` goes low after edge N+2.
- **Frame length:** 10×CLK_PER_BIT clocks (11× with parity).
- **Back-to-back TX:** the stop bit is followed immediately by the next start bit.
- **RX latency:** the stop bit is sampled CLK_PER_BIT/2 plus 2 synchroniser cycles into the stop bit. `rx_valid`/`rx_count` update on the following edge.
- **Counts:** `tx_count` and `tx_ready` update the cycle after a push or pop.
- **Baud tolerance:** RX tolerates ±3 % baud mismatch at CLK_PER_BIT ≥16.
- **Reset mid-frame:** asynchronous reset mid-frame aborts it. `UART_TX` returns high immediately, both FIFOs empty, and the partial RX byte is discarded.

## Configuration
- **`UART_PARITY_EN` defined:** one even-parity bit is inserted after D7 on TX and checked on RX. A parity mismatch is treated as a frame error (`rx_frame_error` pulse, byte dropped). Frame is 11 bits.
- **`UART_PARITY_EN` undefined:** no PARITY state and no parity logic. Frame is 10 bits.

## Test plan
All scenarios use CLK_PER_BIT=4 and FIFO_DEPTH=4 unless noted.
- **Single byte, loopback:** push 0xA5 with `UART_TX`→`UART_RX`. `UART_TX` reads 0,1,0,1,0,0,1,0,1,1 (4 clocks each). `rx_data`=0xA5 with `rx_valid`=1; `rx_frame_error` never pulses.
- **TX full:** push 6 bytes 0x01–0x06 while the first is shifting. `tx_ready` drops after the 5th accept (1 shifting + 4 queued); the 6th is held until `tx_ready` returns. Line shows 6 frames with no idle gaps.
- **RX overflow:** receive 5 bytes with `rx_ready`=0. `rx_count`=4, one `rx_overflow` pulse on the 5th stop bit, FIFO holds bytes 1–4. Popping with `rx_ready`=1 for 4 cycles returns them in order, then `rx_valid`=0.
- **Frame error:** drive a frame with stop bit 0 (data 0x3C). One `rx_frame_error` pulse, `rx_count` stays 0. The next frame, sent after a line-high gap, is received correctly.
- **Glitch and parity:** a 1-clock low glitch on `UART_RX` produces no byte. With `UART_PARITY_EN`, 0x07 sent with parity 0 gives `rx_frame_error`; sent with parity 1 it gives `rx_data`=0x07.
- **Reset mid-frame:** assert `reset` during DATA bit 3 of TX. `UART_TX`=1 and `tx_count`=0 immediately. The next push after release transmits a clean frame.
